// File: rtl/of_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// of_stream_ctrl_if
//   Bundles the pixel-stream handshake and the datapath control/flag signals
//   of the optical-flow stream controller.
//
//   Signals
//     in_valid   source -> ctrl   source pixel valid
//     in_sof     source -> ctrl   first pixel of frame (qualified by in_valid)
//     in_ready   ctrl -> source   controller accepts the pixel this cycle
//     out_ready  sink -> ctrl     sink can take a result this cycle
//     calc_en    ctrl -> dpath    advances every datapath pipeline stage
//     pix_zero   ctrl -> dpath    datapath pixel mux drives zeros (flush)
//     out_valid  ctrl -> sink     vx/vy on the datapath outputs is a real pixel
//     out_sof    ctrl -> sink     with out_valid: output pixel (0,0)
//     out_eol    ctrl -> sink     with out_valid: last column of a line
//     out_eof    ctrl -> sink     with out_valid: last pixel of the frame
//
//   Modports
//     master  environment side (source, sink, datapath)
//     slave   controller side
// ----------------------------------------------------------------------------
interface of_stream_ctrl_if;
    logic in_valid;
    logic in_sof;
    logic in_ready;
    logic out_ready;
    logic calc_en;
    logic pix_zero;
    logic out_valid;
    logic out_sof;
    logic out_eol;
    logic out_eof;

    modport master (
        output in_valid, in_sof, out_ready,
        input  in_ready, calc_en, pix_zero, out_valid, out_sof, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_sof, out_ready,
        output in_ready, calc_en, pix_zero, out_valid, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/of_stream_ctrl.sv
// ----------------------------------------------------------------------------
// of_stream_ctrl
//   Sequences the optical-flow datapath. Turns a valid/ready pixel stream into
//   the datapath clock enable, tracks input and output raster positions, hides
//   the pipeline fill and pushes zero pixels through the pipeline at end of
//   frame so the last real results reach the outputs. Output flags are aligned
//   to the datapath vx/vy outputs.
//
//   Ports
//     clk         datapath clock
//     rst         asynchronous active-high reset
//     s           stream/datapath bundle (of_stream_ctrl_if.slave)
//     busy_o      controller is not idle
//     sync_err_o  one-cycle pulse: start-of-frame seen at a non-zero position
//     frame_cnt_o completed frames, wraps          (OF_CTRL_STATS_EN only)
//     stall_cnt_o RUN/FLUSH cycles with sink stall (OF_CTRL_STATS_EN only)
//
//   Optional feature macro: OF_CTRL_STATS_EN adds the two statistics outputs;
//   without it the ports and their logic are absent.
// ----------------------------------------------------------------------------
module of_stream_ctrl #(
    parameter int FRAME_WIDTH  = 1280,
    parameter int FRAME_HEIGHT = 720,
    parameter int PIPE_LATENCY = 9000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic            clk,
    input  logic            rst,
    of_stream_ctrl_if.slave s,
    output logic            busy_o,
    output logic            sync_err_o
`ifdef OF_CTRL_STATS_EN
    ,
    output logic [31:0]     frame_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] LAT      = CNT_WIDTH'(PIPE_LATENCY);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] in_col_q, in_col_d, in_row_q, in_row_d;
    logic [CNT_WIDTH-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
    logic [CNT_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sync_err_q, sync_err_d;

    logic                 in_ready, calc_en, accept, frame_pix;
    logic                 resync, start, last_in, out_last;
    logic [CNT_WIDTH-1:0] base_col, base_row;

    always_comb begin
        state_d     = state_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        in_ready    = 1'b0;
        calc_en     = 1'b0;
        accept      = 1'b0;
        frame_pix   = 1'b0;
        resync      = 1'b0;
        start       = 1'b0;
        last_in     = 1'b0;
        out_last    = 1'b0;
        base_col    = in_col_q;
        base_row    = in_row_q;

        // In IDLE every offered pixel is taken so a source that starts
        // mid-frame drains; only a start-of-frame pixel enters the datapath.
        unique case (state_q)
            IDLE:    in_ready = s.in_valid;
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = s.out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = s.in_valid & in_ready;

        if (state_q == FLUSH) begin
            calc_en = s.out_ready;
        end else begin
            frame_pix = accept & ((state_q != IDLE) | s.in_sof);
            calc_en   = frame_pix;
        end

        // A start-of-frame in the middle of a frame drops the partial frame
        // and restarts everything with this pixel as (0,0).
        resync     = frame_pix & s.in_sof & (state_q != IDLE) &
                     ((in_col_q != '0) | (in_row_q != '0));
        start      = frame_pix & ((state_q == IDLE) | resync);
        sync_err_d = resync;

        if (start) begin
            base_col = '0;
            base_row = '0;
        end
        last_in = frame_pix & (base_col == COL_LAST) & (base_row == ROW_LAST);

        if (frame_pix) begin
            if (base_col == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (base_row == ROW_LAST) ? '0 : base_row + ONE;
            end else begin
                in_col_d = base_col + ONE;
                in_row_d = base_row;
            end
        end

        // Fill counter saturates at the latency; the calc_en that brings it
        // there is the one whose result is the first real output.
        if (start) begin
            fill_cnt_d = ONE;
        end else if (calc_en && (fill_cnt_q != LAT)) begin
            fill_cnt_d = fill_cnt_q + ONE;
        end
        out_valid_d = calc_en & (fill_cnt_d == LAT);

        out_last = out_valid_q & (out_col_q == COL_LAST) & (out_row_q == ROW_LAST);
        if (start) begin
            out_col_d = '0;
            out_row_d = '0;
        end else if (out_valid_q) begin
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ONE;
            end else begin
                out_col_d = out_col_q + ONE;
            end
        end

        unique case (state_q)
            IDLE, FILL, RUN: begin
                if (frame_pix) begin
                    if (last_in) begin
                        state_d = FLUSH;
                    end else if (fill_cnt_d == LAT) begin
                        state_d = RUN;
                    end else if (start) begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                if (out_last) begin
                    state_d     = IDLE;
                    fill_cnt_d  = '0;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign s.in_ready  = in_ready;
    assign s.calc_en   = calc_en;
    assign s.pix_zero  = (state_q == FLUSH);
    assign s.out_valid = out_valid_q;
    assign s.out_sof   = out_valid_q & (out_col_q == '0) & (out_row_q == '0);
    assign s.out_eol   = out_valid_q & (out_col_q == COL_LAST);
    assign s.out_eof   = out_last;
    assign busy_o      = (state_q != IDLE);
    assign sync_err_o  = sync_err_q;

`ifdef OF_CTRL_STATS_EN
    logic [31:0] frame_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_last) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (((state_q == RUN) || (state_q == FLUSH)) && !s.out_ready &&
                (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_of_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_of_stream_ctrl
//   Directed bench for of_stream_ctrl with a 4x3 frame. Instance A uses a
//   pipeline latency of 5, instance B a latency of 20 (longer than a frame).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_of_stream_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int LA   = 5;
    localparam int LB   = 20;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    of_stream_ctrl_if ia ();
    of_stream_ctrl_if ib ();
    logic busy_a, serr_a, busy_b, serr_b;
`ifdef OF_CTRL_STATS_EN
    logic [31:0] fcnt_a, scnt_a, fcnt_b, scnt_b;
`endif

    of_stream_ctrl #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIPE_LATENCY(LA), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .s(ia), .busy_o(busy_a), .sync_err_o(serr_a)
`ifdef OF_CTRL_STATS_EN
        , .frame_cnt_o(fcnt_a), .stall_cnt_o(scnt_a)
`endif
    );

    of_stream_ctrl #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIPE_LATENCY(LB), .CNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .rst(rst), .s(ib), .busy_o(busy_b), .sync_err_o(serr_b)
`ifdef OF_CTRL_STATS_EN
        , .frame_cnt_o(fcnt_b), .stall_cnt_o(scnt_b)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitors (sampled on the falling edge)
    int          cyc = 0;
    int          clr_req_a = 0, clr_seen_a = 0;
    int          a_n = 0, a_first_ov = -1, a_calc_n = 0, a_calc5_cyc = -1, a_calc_bad = 0;
    logic [11:0] a_sof_m = '0, a_eol_m = '0, a_eof_m = '0;
    int          b_n = 0, b_first_ov = -1, b_first_pz = -1, b_calc_n = 0, b_calc_at_ov = -1;
    logic [11:0] b_sof_m = '0, b_eol_m = '0, b_eof_m = '0;

    always @(negedge clk) begin
        cyc++;
        if (clr_req_a != clr_seen_a) begin
            clr_seen_a  = clr_req_a;
            a_n         = 0;
            a_first_ov  = -1;
            a_calc_n    = 0;
            a_calc5_cyc = -1;
            a_calc_bad  = 0;
            a_sof_m     = '0;
            a_eol_m     = '0;
            a_eof_m     = '0;
        end
        if (ia.calc_en) begin
            a_calc_n++;
            if (a_calc_n == LA) a_calc5_cyc = cyc;
        end
        if (!ia.pix_zero && (ia.calc_en !== (ia.in_valid & ia.in_ready & (busy_a | ia.in_sof))))
            a_calc_bad++;
        if (ia.out_valid) begin
            if (a_n == 0) a_first_ov = cyc;
            a_sof_m = a_sof_m | (12'(ia.out_sof) << a_n);
            a_eol_m = a_eol_m | (12'(ia.out_eol) << a_n);
            a_eof_m = a_eof_m | (12'(ia.out_eof) << a_n);
            a_n++;
        end

        if (ib.pix_zero && b_first_pz < 0) b_first_pz = cyc;
        if (ib.out_valid) begin
            if (b_n == 0) begin
                b_first_ov   = cyc;
                b_calc_at_ov = b_calc_n;
            end
            b_sof_m = b_sof_m | (12'(ib.out_sof) << b_n);
            b_eol_m = b_eol_m | (12'(ib.out_eol) << b_n);
            b_eof_m = b_eof_m | (12'(ib.out_eof) << b_n);
            b_n++;
        end
        if (ib.calc_en) b_calc_n++;
    end

    task automatic send_a(input logic sof, input int gap);
        int t = 0;
        ia.in_valid = 1'b1;
        ia.in_sof   = sof;
        @(negedge clk);
        while (!ia.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_a_timeout", 32'(t), 0);
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        ia.in_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame_a(input int gap);
        send_a(1'b1, gap);
        for (int i = 1; i < NPIX; i++) send_a(1'b0, gap);
    endtask

    task automatic wait_a(input string tag);
        int t = 0;
        while ((a_n < NPIX || busy_a) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_done"}, 32'(t < 400), 1);
    endtask

    task automatic chk_frame_a(input string tag);
        chk({tag, "_nout"}, 32'(a_n), NPIX);
        chk({tag, "_sof"},  32'(a_sof_m), 32'h001);
        chk({tag, "_eol"},  32'(a_eol_m), 32'h888);
        chk({tag, "_eof"},  32'(a_eof_m), 32'h800);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_calc"}, 32'(a_calc_bad), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int acc;
        rst = 1'b1;
        ia.in_valid = 1'b0; ia.in_sof = 1'b0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_sof = 1'b0; ib.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(ia.in_ready), 0);
        chk("rst_calc_en",   32'(ia.calc_en), 0);
        chk("rst_pix_zero",  32'(ia.pix_zero), 0);
        chk("rst_out_valid", 32'(ia.out_valid), 0);
        chk("rst_flags",     32'({ia.out_sof, ia.out_eol, ia.out_eof}), 0);
        chk("rst_busy",      32'(busy_a), 0);
        chk("rst_sync_err",  32'(serr_a), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Non-start pixel in IDLE is drained without touching the datapath
        ia.in_valid = 1'b1; ia.in_sof = 1'b0;
        @(negedge clk);
        chk("idle_drain_rdy", 32'(ia.in_ready), 1);
        chk("idle_drain_cen", 32'(ia.calc_en), 0);
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        chk("idle_drain_busy", 32'(busy_a), 0);

        // Continuous frame
        clr_req_a++;
        @(posedge clk); #1;
        frame_a(0);
        wait_a("cont");
        chk_frame_a("cont");
        chk("cont_first_ov", 32'(a_first_ov - a_calc5_cyc), 1);

        // Valid toggling 1/0
        clr_req_a++;
        @(posedge clk); #1;
        frame_a(1);
        wait_a("toggle");
        chk_frame_a("toggle");

        // Sink stalls of 3 cycles in RUN and in FLUSH
        clr_req_a++;
        @(posedge clk); #1;
        send_a(1'b1, 0);
        for (int i = 1; i < 8; i++) send_a(1'b0, 0);
        ia.out_ready = 1'b0; ia.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("run_stall_rdy", 32'(ia.in_ready), 0);
            chk("run_stall_cen", 32'(ia.calc_en), 0);
            if (k > 0) chk("run_stall_ov", 32'(ia.out_valid), 0);
            @(posedge clk); #1;
        end
        ia.out_ready = 1'b1;
        for (int i = 8; i < NPIX; i++) send_a(1'b0, 0);
        @(posedge clk); #1;
        ia.out_ready = 1'b0; ia.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_stall_rdy", 32'(ia.in_ready), 0);
            chk("flush_stall_cen", 32'(ia.calc_en), 0);
            if (k > 0) chk("flush_stall_ov", 32'(ia.out_valid), 0);
            @(posedge clk); #1;
        end
        ia.out_ready = 1'b1; ia.in_valid = 1'b0;
        wait_a("stall");
        chk_frame_a("stall");

        // Start-of-frame at input (2,1)
        clr_req_a++;
        @(posedge clk); #1;
        send_a(1'b1, 0);
        for (int i = 1; i < 6; i++) send_a(1'b0, 0);
        send_a(1'b1, 0);
        chk("resync_old_nout", 32'(a_n), 2);
        chk("resync_old_sof", 32'(a_sof_m), 32'h001);
        clr_req_a++;
        ia.out_ready = 1'b0; ia.in_valid = 1'b1; ia.in_sof = 1'b0;
        @(negedge clk);
        chk("resync_err_hi", 32'(serr_a), 1);
        chk("resync_fill_rdy", 32'(ia.in_ready), 1);
        chk("resync_fill_cen", 32'(ia.calc_en), 1);
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        @(negedge clk);
        chk("resync_err_lo", 32'(serr_a), 0);
        @(posedge clk); #1;
        for (int i = 2; i < NPIX; i++) send_a(1'b0, 0);
        wait_a("resync");
        chk_frame_a("resync");

        // Reset in the middle of RUN
        clr_req_a++;
        @(posedge clk); #1;
        send_a(1'b1, 0);
        for (int i = 1; i < 7; i++) send_a(1'b0, 0);
        rst = 1'b1; ia.in_valid = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_ov", 32'(ia.out_valid), 0);
        chk("midrst_cen", 32'(ia.calc_en), 0);
        chk("midrst_rdy", 32'(ia.in_ready), 0);
        chk("midrst_pz", 32'(ia.pix_zero), 0);
        chk("midrst_flags", 32'({ia.out_sof, ia.out_eol, ia.out_eof, serr_a}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr_req_a++;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_out", 32'(a_n), 0);
        frame_a(0);
        wait_a("after_rst");
        chk_frame_a("after_rst");

        // Instance B: latency longer than the frame
        ib.in_valid = 1'b1; ib.in_sof = 1'b1;
        acc = 0; t = 0;
        while (acc < NPIX && t < 200) begin
            @(negedge clk);
            if (ib.in_ready) acc++;
            @(posedge clk); #1;
            ib.in_sof = (acc == 0);
            t++;
        end
        ib.in_valid = 1'b0; ib.in_sof = 1'b0;
        t = 0;
        while ((b_n < NPIX || busy_b) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("lat20_done", 32'(t < 400), 1);
        chk("lat20_nout", 32'(b_n), NPIX);
        chk("lat20_sof", 32'(b_sof_m), 32'h001);
        chk("lat20_eol", 32'(b_eol_m), 32'h888);
        chk("lat20_eof", 32'(b_eof_m), 32'h800);
        chk("lat20_calc_first", 32'(b_calc_at_ov), LB);
        chk("lat20_flush_first", 32'(b_first_pz >= 0 && b_first_pz < b_first_ov), 1);
        chk("lat20_busy", 32'(busy_b), 0);

`ifdef OF_CTRL_STATS_EN
        chk("stats_frames_a", fcnt_a, 1);
        chk("stats_stalls_a", scnt_a, 0);
        chk("stats_frames_b", fcnt_b, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
